// File: rtl/mdu_sequencer.sv
// Iterative unsigned multiply/divide unit owning the HI/LO pair.
// Radix-2 shift-add multiply or restoring divide, one bit per cycle over WIDTH cycles.
module mdu_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;   // multiplicand or divisor
  logic [WIDTH-1:0]  acc_q, acc_d;     // product high word or partial remainder
  logic [WIDTH-1:0]  low_q, low_d;     // multiplier or dividend/quotient
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              dbz_q, dbz_d;

  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shift;
  logic [WIDTH:0]    div_trial;
  logic [WIDTH-1:0]  rem_new;
  logic [WIDTH-1:0]  quot_new;
  logic              accept;
  logic              last;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    low_d     = low_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;

    mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, opnd_q} : '0);
    // Remainder shifted left with the next dividend bit; bit WIDTH of the trial is the borrow.
    div_shift = {acc_q, low_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    rem_new   = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
    quot_new  = {low_q[WIDTH-2:0], ~div_trial[WIDTH]};

    accept    = start & ((state_q == StIdle) | (state_q == StDone));
    last      = (cnt_q == LastCnt);

    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          cnt_d   = '0;
          acc_d   = '0;
          opnd_d  = op ? b : a;
          low_d   = op ? a : b;
          state_d = op ? StDiv : StMul;
        end
      end
      StMul: begin
        acc_d = mul_sum[WIDTH:1];
        low_d = {mul_sum[0], low_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          hi_d    = mul_sum[WIDTH:1];
          lo_d    = {mul_sum[0], low_q[WIDTH-1:1]};
          dbz_d   = 1'b0;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDiv: begin
        acc_d = rem_new;
        low_d = quot_new;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          hi_d    = rem_new;
          lo_d    = quot_new;
          dbz_d   = (opnd_q == '0);
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      low_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      low_q   <= low_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == StMul) | (state_q == StDiv);
  assign stall       = rd_req & busy;
  assign done        = (state_q == StDone);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: cycle-level arithmetic model checked every cycle,
// plus directed operations with hand-computed results.
module tb_mdu_sequencer;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic         rd_req = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, stall, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int fails = 0;

  mdu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .rd_req(rd_req),
    .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: remaining-cycle count plus the result precomputed with plain arithmetic.
  int           m_left = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
  logic         m_dbz = 1'b0, r_dbz = 1'b0, m_done = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_dbz  <= 1'b0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= r_hi;
          m_lo   <= r_lo;
          m_dbz  <= r_dbz;
          m_done <= 1'b1;
        end
      end else if (start) begin
        m_left <= W;
        if (op) begin
          r_lo  <= (b == 0) ? '1 : a / b;
          r_hi  <= (b == 0) ? a : a % b;
          r_dbz <= (b == 0);
        end else begin
          {r_hi, r_lo} <= {32'b0, a} * {32'b0, b};
          r_dbz        <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    check("busy", 64'(busy), 64'(m_left != 0));
    check("stall", 64'(stall), 64'(rd_req && (m_left != 0)));
    check("done", 64'(done), 64'(m_done));
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
    check("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
  end

  task automatic launch(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
  endtask

  // Call right after launch at a negedge; returns at the negedge where done is seen.
  task automatic wait_result(output int n);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    n     = 1;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n;
  int stalls;
  bit fin;

  initial begin
    repeat (2) @(negedge clk);
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    reset = 1'b0;

    // 1: 0x10000 * 0x10000
    @(negedge clk);
    launch(1'b0, 32'h0001_0000, 32'h0001_0000);
    wait_result(n);
    check("t1_latency", 64'(n), 64'd33);
    check("t1_hi", 64'(hi), 64'h1);
    check("t1_lo", 64'(lo), 64'h0);

    // 2: max * max
    @(negedge clk);
    launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result(n);
    check("t2_hi", 64'(hi), 64'hFFFF_FFFE);
    check("t2_lo", 64'(lo), 64'h1);
    check("t2_dbz", 64'(div_by_zero), 64'h0);

    // 3: 100 / 7, then divide by zero
    @(negedge clk);
    launch(1'b1, 32'd100, 32'd7);
    wait_result(n);
    check("t3_lo", 64'(lo), 64'd14);
    check("t3_hi", 64'(hi), 64'd2);
    @(negedge clk);
    launch(1'b1, 32'h1234, 32'h0);
    wait_result(n);
    check("t3z_latency", 64'(n), 64'd33);
    check("t3z_lo", 64'(lo), 64'hFFFF_FFFF);
    check("t3z_hi", 64'(hi), 64'h1234);
    check("t3z_dbz", 64'(div_by_zero), 64'h1);

    // Dividend smaller than divisor, and divisor of one
    @(negedge clk);
    launch(1'b1, 32'd5, 32'd9);
    wait_result(n);
    check("t3s_lo", 64'(lo), 64'd0);
    check("t3s_hi", 64'(hi), 64'd5);
    check("t3s_dbz_clear", 64'(div_by_zero), 64'h0);
    @(negedge clk);
    launch(1'b1, 32'hFFFF_FFFF, 32'd1);
    wait_result(n);
    check("t3o_lo", 64'(lo), 64'hFFFF_FFFF);
    check("t3o_hi", 64'(hi), 64'h0);

    // 4: rd_req held through the op, and a start mid-operation that must be ignored
    @(negedge clk);
    launch(1'b0, 32'd6, 32'd7);
    @(negedge clk);
    start  = 1'b0;
    rd_req = 1'b1;
    fin    = 1'b0;
    stalls = 0;
    for (int i = 0; i < 60 && !fin; i++) begin
      #1;
      if (stall) stalls++;
      if (done) fin = 1'b1;
      else begin
        @(negedge clk);
        start = (i == 9);
        op    = 1'b1;
        a     = 32'd9;
        b     = 32'd3;
      end
    end
    check("t4_finished", 64'(fin), 64'h1);
    check("t4_stall_cycles", 64'(stalls), 64'd32);
    check("t4_done_no_stall", 64'(stall), 64'h0);
    check("t4_lo", 64'(lo), 64'd42);
    check("t4_hi", 64'(hi), 64'd0);
    rd_req = 1'b0;

    // 5: back-to-back accept in the DONE cycle
    launch(1'b0, 32'h0000_DEAD, 32'h10);
    wait_result(n);
    check("t5_latency", 64'(n), 64'd33);
    check("t5_lo", 64'(lo), 64'h000D_EAD0);
    check("t5_hi", 64'(hi), 64'h0);

    // 6: async reset mid-divide, then 3 * 5
    @(negedge clk);
    launch(1'b1, 32'd1000, 32'd0);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_busy", 64'(busy), 64'h0);
    check("t6_done", 64'(done), 64'h0);
    check("t6_hi", 64'(hi), 64'h0);
    check("t6_lo", 64'(lo), 64'h0);
    check("t6_dbz", 64'(div_by_zero), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    launch(1'b0, 32'd3, 32'd5);
    wait_result(n);
    check("t6_lo_after", 64'(lo), 64'd15);
    check("t6_hi_after", 64'(hi), 64'd0);
    check("t6_latency", 64'(n), 64'd33);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
